// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - fetch/data arbiter and access sequencer for the unified byte memory
module umem_arbiter #(
    parameter int MEM_BYTES  = 256,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic        mem_half,
    output logic        mem_byte,
    output logic        mem_fetch,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC_F, ACC_D} state_t;

    state_t      state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [3:0]  streak;

    logic f_elig, d_elig, grant_f, grant_d, f_bad, d_bad, acc_f, acc_d;

    // Bounds use a 33-bit last-byte address so accesses near 2^32 cannot wrap into range
    function automatic logic bad_access(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] last;
        logic        mis;
        case (size)
            2'd0:    begin last = {1'b0, addr};          mis = 1'b0;             end
            2'd1:    begin last = {1'b0, addr} + 33'd1;  mis = addr[0];          end
            default: begin last = {1'b0, addr} + 33'd3;  mis = (addr[1:0] != 2'b00); end
        endcase
        return (size == 2'd3) || mis || (last > 33'(MEM_BYTES - 1));
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'd0:    return uns ? {24'd0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
            2'd1:    return uns ? {16'd0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default: return r;
        endcase
    endfunction

    // A port whose response is on the wire this cycle is masked so it is not served twice
    assign f_elig  = if_req && !if_valid;
    assign d_elig  = d_req && !d_valid;
    assign grant_d = (state == IDLE) && d_elig && (!f_elig || streak != 4'(MAX_STREAK));
    assign grant_f = (state == IDLE) && f_elig && !grant_d;
    assign f_bad   = bad_access(if_addr, 2'd2);
    assign d_bad   = bad_access(d_addr, d_size);

    assign acc_f     = (state == ACC_F);
    assign acc_d     = (state == ACC_D);
    assign mem_fetch = acc_f;
    assign mem_re    = !rst && (acc_f || (acc_d && !lat_we));
    assign mem_we    = !rst && acc_d && lat_we;
    assign mem_half  = acc_d && (lat_size == 2'd1);
    assign mem_byte  = acc_d && (lat_size == 2'd0);
    assign mem_addr  = (acc_f || acc_d) ? lat_addr : 32'd0;
    assign mem_wdata = (acc_d && lat_we) ? lat_wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'd0;
            if_valid  <= 1'b0;
            if_rdata  <= 32'd0;
            if_err    <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= 32'd0;
            d_err     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (!if_req || grant_f)
                streak <= 4'd0;
            else if (grant_d && streak < 4'(MAX_STREAK))
                streak <= streak + 4'd1;

            case (state)
                IDLE: begin
                    if (grant_f) begin
                        if (f_bad) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= 32'd0;
                        end else begin
                            lat_addr <= if_addr;
                            state    <= ACC_F;
                        end
                    end else if (grant_d) begin
                        if (d_bad) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'd0;
                        end else begin
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                            lat_we    <= d_we;
                            lat_uns   <= d_unsigned;
                            lat_size  <= d_size;
                            state     <= ACC_D;
                        end
                    end
                end
                ACC_F: begin
                    if_rdata <= mem_rdata;
                    if_err   <= 1'b0;
                    if_valid <= 1'b1;
                    state    <= IDLE;
                end
                ACC_D: begin
                    d_rdata <= lat_we ? 32'd0 : extend(mem_rdata, lat_size, lat_uns);
                    d_err   <= 1'b0;
                    d_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
